uart_rx_edge_sampler: RTL
=========================

# uart_rx_edge_sampler

Timing front end of the UART receiver. It sits directly upstream of the receiver control FSM and supplies the FSM's `edge_cnt`, `bit_cnt` and sampled line value. The block counts oversampling clock edges within each bit period and counts bits within the frame. It also takes a 3-sample majority vote of `RX_IN` around mid-bit to reject short glitches.

## Interface
Parameters:
- none. Widths are fixed: 6-bit prescale and edge count, 4-bit bit count.

Ports:
- `CLK` in 1: receiver oversampling clock.
- `RST` in 1: reset, asynchronous, active-low.
- `RX_IN` in 1: serial line, already synchronised to `CLK`.
- `Prescale` in 6: oversampling ratio. Supported values are 8, 16 and 32.
- `PAR_EN` in 1: parity bit present in the frame.
- `enable` in 1: counter enable, driven by the FSM.
- `dat_samp_en` in 1: sampler enable, driven by the FSM.
- `edge_cnt` out 6: edge index within the current bit, 0..Prescale-1.
- `bit_cnt` out 4: bit index within the frame. 0 is the start bit; 1..8 are data bits; then parity if present; then stop.
- `sampled_bit` out 1: majority-voted line value for the current bit.

## Operation
- Reset values: `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, sample register=3'b111.
- Define `last_bit` = `PAR_EN` ? 10 : 9. The stop bit is at index `last_bit`.
- Counter rules, evaluated at each posedge:
  - `enable`=0: `edge_cnt` <= 0 and `bit_cnt` <= 0. This holds regardless of the current values.
  - `enable`=1 and `edge_cnt` >= `Prescale`-1: `edge_cnt` <= 0. In the same cycle, `bit_cnt` <= (`bit_cnt` == `last_bit`) ? 0 : `bit_cnt`+1. If `bit_cnt` is already above `last_bit` (for example, `PAR_EN` changed mid-frame), `bit_cnt` <= 0.
  - `enable`=1 otherwise: `edge_cnt` <= `edge_cnt`+1, and `bit_cnt` holds.
- The `>=` compare is mandatory. `edge_cnt` can never run past `Prescale`-1 even if `Prescale` decreases mid-bit.
- Back-to-back frames: if `enable` stays 1 across the stop-to-start transition, counting continues seamlessly from `bit_cnt`=0, `edge_cnt`=0.
- Sampler, with `H` = `Prescale`>>1, computed in 6 bits:
  - `dat_samp_en`=0: sample register <= 3'b111 and `sampled_bit` <= 1.
  - `dat_samp_en`=1:
    - `edge_cnt`==`H`-1: capture `RX_IN` into s0.
    - `edge_cnt`==`H`: capture `RX_IN` into s1.
    - `edge_cnt`==`H`+1: capture `RX_IN` into s2.
    - `edge_cnt`==`H`+2: `sampled_bit` <= majority(s0,s1,s2), i.e. (s0&s1)|(s0&s2)|(s1&s2).
    - Otherwise `sampled_bit` holds.
- Sample-point arithmetic is 6-bit unsigned; no overflow occurs for the supported `Prescale` values.
- For `Prescale` < 8 or odd `Prescale`, the sampled value is unspecified. The counters must still wrap legally.
- Purely registered outputs; no combinational path from any input to any output.

## Timing
- `edge_cnt` and `bit_cnt` change only on posedge `CLK`, except that `RST` clears them asynchronously.
- First cycle with `enable`=1: `edge_cnt`=0 is visible during that cycle. `edge_cnt`=1 is visible in the following cycle.
- `sampled_bit` for bit n updates on the posedge where `edge_cnt` goes from `H`+2 to `H`+3.
  - It is stable while `edge_cnt`==`H`+3, the FSM's check point.
  - It holds until the next bit's `H`+2 edge.
- `bit_cnt` increments on the same posedge where `edge_cnt` wraps from `Prescale`-1 to 0.
- `RST` asserted mid-frame:
  - All outputs return to their reset values immediately.
  - After release, counting restarts only on `enable`=1.
- If `enable` and `dat_samp_en` drop in the same cycle, both clears take effect on the next posedge.

## Test plan
- `Prescale`=8, `PAR_EN`=0, `enable` held high for 80 cycles, frame byte 0xA5 (LSB first, start 0, stop 1):
  - `edge_cnt` runs 0..7 and wraps.
  - `bit_cnt` runs 0..9, then 0.
  - `sampled_bit` at each `edge_cnt`==7 follows 0,1,0,1,0,0,1,0,1,1.
- `PAR_EN`=1, `Prescale`=16: `bit_cnt` reaches 10, then wraps to 0 after 176 enabled cycles. It never reaches 11.
- `Prescale`=32, line low for bit 0 except a 1-cycle high pulse at `edge_cnt`=16:
  - Samples are taken at edges 15, 16 and 17.
  - The majority vote gives 0, so `sampled_bit`=0 at `edge_cnt`=19.
  - A 2-cycle high pulse at edges 16 and 17 gives `sampled_bit`=1.
- `enable` dropped at `bit_cnt`=5, `edge_cnt`=3: the next cycle shows `edge_cnt`=0 and `bit_cnt`=0. Re-enabling restarts counting from 0.
- `RST` low mid-frame at `bit_cnt`=4:
  - `edge_cnt`=0, `bit_cnt`=0 and `sampled_bit`=1 appear asynchronously.
  - They hold until `RST` is released and `enable`=1.
- `Prescale` changed from 16 to 8 while `edge_cnt`=12: on the next posedge `edge_cnt` wraps to 0 and `bit_cnt` increments.

Source files
------------

// File: rtl/uart_rx_edge_sampler.sv
// uart_rx_edge_sampler
// Timing front end of the UART receiver. Counts oversampling edges within a
// bit period and bits within a frame, and takes a 3-sample majority vote of
// the serial line around mid-bit so that single-cycle glitches are rejected.
// All outputs come straight from registers.
module uart_rx_edge_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       enable,
    input  logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       sampled_bit
);

    logic [5:0] edge_cnt_reg;
    logic [5:0] edge_cnt_next;
    logic [3:0] bit_cnt_reg;
    logic [3:0] bit_cnt_next;
    logic [2:0] samp_reg;
    logic [2:0] samp_next;
    logic [2:0] samp_hit;
    logic       sampled_bit_reg;
    logic       sampled_bit_next;

    logic [3:0] last_bit;
    logic [5:0] edge_last;
    logic       edge_wrap;
    logic [5:0] half;
    logic [5:0] vote_point;
    logic       vote;

    // Stop bit index: one extra bit slot when parity is present.
    assign last_bit   = PAR_EN ? 4'd10 : 4'd9;
    assign edge_last  = Prescale - 6'd1;
    // ">=" keeps edge_cnt bounded even if Prescale shrinks mid-bit.
    assign edge_wrap  = (edge_cnt_reg >= edge_last);
    assign half       = Prescale >> 1;
    assign vote_point = half + 6'd2;
    assign vote       = (samp_reg[0] & samp_reg[1]) |
                        (samp_reg[0] & samp_reg[2]) |
                        (samp_reg[1] & samp_reg[2]);

    // Three consecutive sample points: H-1, H, H+1.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_samp_point
            logic [5:0] samp_point;
            assign samp_point   = half - 6'd1 + 6'(gi);
            assign samp_hit[gi] = (edge_cnt_reg == samp_point);
        end
    endgenerate

    // Next-state logic for the edge and bit counters.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        if (!enable) begin
            edge_cnt_next = 6'd0;
            bit_cnt_next  = 4'd0;
        end else if (edge_wrap) begin
            edge_cnt_next = 6'd0;
            // Also catches bit_cnt above last_bit after a mid-frame PAR_EN change.
            bit_cnt_next  = (bit_cnt_reg >= last_bit) ? 4'd0 : bit_cnt_reg + 4'd1;
        end else begin
            edge_cnt_next = edge_cnt_reg + 6'd1;
        end
    end

    // Next-state logic for the sample register and voted bit.
    always_comb begin
        samp_next        = samp_reg;
        sampled_bit_next = sampled_bit_reg;
        if (!dat_samp_en) begin
            samp_next        = 3'b111;
            sampled_bit_next = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (samp_hit[i]) begin
                    samp_next[i] = RX_IN;
                end
            end
            if (edge_cnt_reg == vote_point) begin
                sampled_bit_next = vote;
            end
        end
    end

    // Counter registers, cleared asynchronously by RST.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_reg <= 6'd0;
            bit_cnt_reg  <= 4'd0;
        end else begin
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    // Sample and vote registers, idle-high when reset or disabled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_reg        <= 3'b111;
            sampled_bit_reg <= 1'b1;
        end else begin
            samp_reg        <= samp_next;
            sampled_bit_reg <= sampled_bit_next;
        end
    end

    assign edge_cnt    = edge_cnt_reg;
    assign bit_cnt     = bit_cnt_reg;
    assign sampled_bit = sampled_bit_reg;

endmodule
